eth_tx_clkgen: RTL and testbench
================================

Name: eth_tx_clkgen

Overview:
- Single-clock Ethernet TX clock generator for 1000/100/10 Mb operation, all speeds derived from one fast reference clock.
- Per speed, it produces:
  - a 50%-duty DDR output pattern (ddr_h/ddr_l), which drives a DDR output cell that forwards the TX clock to the PHY;
  - a one-cycle clock-enable (clk_en) marking the start of each output clock period, for the TX datapath.
- Speed changes and start/stop take effect only at output-period boundaries, so the forwarded clock never glitches.
- Sits between the MAC speed-control logic and the RGMII/GMII TX output registers.

Parameters:
DIV_1000, 1, clk cycles per output period in gigabit mode (>=1)
DIV_100, 5, clk cycles per output period in 100 Mb mode (>=1)
DIV_10, 50, clk cycles per output period in 10 Mb mode (>=1)
CNT_W, 8, phase counter width; every DIV_* <= 2**CNT_W

Ports:
clk  in  1  reference clock (125 MHz at defaults)
reset  in  1  synchronous, active-high reset
run_en  in  1  1 = generate clock; 0 = stop after current period completes
eth_mode  in  1  gigabit select (priority over ena_10)
ena_10  in  1  10 Mb select when eth_mode=0; eth_mode=0, ena_10=0 selects 100 Mb
ddr_h  out  1  DDR cell data for first (rising-edge) half of clk cycle
ddr_l  out  1  DDR cell data for second (falling-edge) half of clk cycle
clk_en  out  1  one-cycle pulse at start of each output period
running  out  1  1 while the RUN state is active (registered)
speed  out  2  active speed: 2'b10 = 1000, 2'b00 = 100, 2'b01 = 10
mode_chg  out  1  one-cycle pulse when a different speed is loaded at a period boundary

Behaviour:
- Requested speed:
  - eth_mode=1 -> 1000 (DIV_1000);
  - else ena_10=1 -> 10 (DIV_10);
  - else 100 (DIV_100).
- Internal state:
  - state ∈ {STOP, RUN};
  - phase counter ph (CNT_W bits);
  - active divisor div;
  - active speed code.
- Reset: state=STOP, ph=0, div=DIV_100, speed=2'b00. Every output is 0 on the cycle after reset is sampled high, including mid-period; no period completion is required.
- STOP:
  - ph held at 0; ddr_h=ddr_l=clk_en=running=0.
  - If run_en=1: load requested speed/div, ph<=0, go to RUN.
  - mode_chg pulses on this load if the new speed differs from the stored speed.
- RUN:
  - If ph != div-1: ph<=ph+1.
  - At ph==div-1 (last cycle of period), with run_en=0: go to STOP, ph<=0.
  - At ph==div-1, with run_en=1: ph<=0. Sample the requested speed; if it differs from the active one, load the new div/speed and pulse mode_chg.
- Speed inputs are ignored at every ph other than div-1. run_en deassertion is honoured only at div-1.
- Output decode, using half-slot indices 2*ph (ddr_h) and 2*ph+1 (ddr_l), evaluated at CNT_W+1 bits:
  - ddr_h = (2*ph < div);
  - ddr_l = (2*ph+1 < div);
  - clk_en = (ph==0);
  - All three are forced to 0 in STOP.
  - Result: exactly div high half-slots per 2*div, so odd divisors also give 50% duty.
- Latency:
  - ddr_h, ddr_l, clk_en, running, speed and mode_chg are all registered from the current state/ph, so all are mutually aligned.
  - The first ddr_h=1/clk_en=1 appears 2 cycles after run_en is first sampled 1 in STOP.
- div=1: ph stays 0; clk_en=1 every cycle; ddr_h=1, ddr_l=0 continuously (forwarded clock = clk).
- Counter wrap: ph never exceeds div-1. A speed change always restarts at ph=0.

Test Plan:
- Reset, then run_en=1, eth_mode=0, ena_10=0 (100 Mb):
  - first clk_en at cycle 2 after run_en;
  - then clk_en every 5 cycles;
  - (ddr_h,ddr_l) per period = (1,1),(1,1),(1,0),(0,0),(0,0);
  - speed=00; mode_chg=0 (same speed as reset).
- Gigabit: eth_mode=1 from STOP -> mode_chg one pulse; speed=10; clk_en=1, ddr_h=1, ddr_l=0 every cycle.
- 10 Mb: ena_10=1 -> period 50 cycles; ddr_h=ddr_l=1 for ph 0..24, 0 for ph 25..49; exactly one clk_en per 50 cycles.
- Speed change mid-period: running 10 Mb, set eth_mode=1 at ph=10 -> still 40 more cycles of 10 Mb pattern. Then mode_chg pulses once at the boundary and 125 MHz pattern starts; no half-slot run shorter than one half-slot of either speed.
- Stop: running 100 Mb, drop run_en at ph=1 -> period completes (ph 2,3,4), then all outputs 0, running=0. Re-assert run_en -> restart at ph=0 after 2 cycles.
- Reset mid-period: reset high at ph=20 in 10 Mb -> next cycle all outputs 0, speed=00, state STOP regardless of run_en.

Source files
------------

// File: rtl/eth_tx_clkgen.sv
// -----------------------------------------------------------------------------
// eth_tx_clkgen
//
// Ethernet TX clock generator for 1000/100/10 Mb operation. Every speed is
// derived from the single reference clock `clk` by a programmable phase
// counter. For each output clock period it produces:
//   - a 50%-duty DDR pattern (ddr_h / ddr_l) for the DDR output cell that
//     forwards the TX clock to the PHY, and
//   - a one-cycle clk_en at the start of the period for the TX datapath.
// Speed changes and start/stop are applied only on the last cycle of a
// period, so the forwarded clock never produces a runt half-cycle.
//
// Ports:
//   clk       in   reference clock (125 MHz at default divisors)
//   reset     in   synchronous, active-high reset
//   run_en    in   1 = generate clock, 0 = stop once the current period ends
//   eth_mode  in   gigabit select (takes priority over ena_10)
//   ena_10    in   10 Mb select when eth_mode = 0; both 0 selects 100 Mb
//   ddr_h     out  DDR data for the rising-edge half of the clk cycle
//   ddr_l     out  DDR data for the falling-edge half of the clk cycle
//   clk_en    out  one-cycle pulse at the start of each output period
//   running   out  1 while the generator is in RUN
//   speed     out  active speed: 2'b10 = 1000, 2'b00 = 100, 2'b01 = 10
//   mode_chg  out  one-cycle pulse when a different speed is loaded
//
// All outputs are registered from the current state/phase, so they are
// mutually aligned: mode_chg and the new speed code appear together with
// the first clk_en of the period that uses the new speed.
// -----------------------------------------------------------------------------
module eth_tx_clkgen #(
    parameter int DIV_1000 = 1,
    parameter int DIV_100  = 5,
    parameter int DIV_10   = 50,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_en,
    input  logic       eth_mode,
    input  logic       ena_10,
    output logic       ddr_h,
    output logic       ddr_l,
    output logic       clk_en,
    output logic       running,
    output logic [1:0] speed,
    output logic       mode_chg
);

    // Divisors may equal 2**CNT_W, so they need one extra bit.
    localparam int DW = CNT_W + 1;

    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_100  = 2'b00;
    localparam logic [1:0] SPD_10   = 2'b01;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Core state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] ph_q,    ph_d;
    logic [DW-1:0]    div_q,   div_d;
    logic [1:0]       spd_q,   spd_d;
    logic             chg_q,   chg_d;   // set on the cycle after a speed load

    // Output registers
    logic             ddr_h_q,    ddr_h_d;
    logic             ddr_l_q,    ddr_l_d;
    logic             clk_en_q,   clk_en_d;
    logic             running_q,  running_d;
    logic [1:0]       speed_q,    speed_d;
    logic             mode_chg_q, mode_chg_d;

    // Requested speed decode
    logic [DW-1:0]    req_div;
    logic [1:0]       req_spd;
    logic             last_ph;

    always_comb begin
        req_div = DW'(DIV_100);
        req_spd = SPD_100;
        if (eth_mode) begin
            req_div = DW'(DIV_1000);
            req_spd = SPD_1000;
        end else if (ena_10) begin
            req_div = DW'(DIV_10);
            req_spd = SPD_10;
        end
    end

    assign last_ph = ({1'b0, ph_q} == (div_q - DW'(1)));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        div_d   = div_q;
        spd_d   = spd_q;
        chg_d   = 1'b0;

        unique case (state_q)
            ST_STOP: begin
                ph_d = '0;
                if (run_en) begin
                    state_d = ST_RUN;
                    div_d   = req_div;
                    spd_d   = req_spd;
                    chg_d   = (req_spd != spd_q);
                end
            end
            ST_RUN: begin
                if (!last_ph) begin
                    ph_d = ph_q + CNT_W'(1);
                end else if (!run_en) begin
                    state_d = ST_STOP;
                    ph_d    = '0;
                end else begin
                    // Period boundary: the only point where speed is sampled.
                    ph_d = '0;
                    if (req_spd != spd_q) begin
                        div_d = req_div;
                        spd_d = req_spd;
                        chg_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_STOP;
                ph_d    = '0;
            end
        endcase
    end

    // Output decode from the current state/phase. Half-slot 2*ph feeds the
    // rising half and 2*ph+1 the falling half; the first div of the 2*div
    // half-slots are high, which keeps odd divisors at 50% duty.
    always_comb begin
        ddr_h_d    = 1'b0;
        ddr_l_d    = 1'b0;
        clk_en_d   = 1'b0;
        running_d  = 1'b0;
        speed_d    = spd_q;
        mode_chg_d = chg_q;
        if (state_q == ST_RUN) begin
            ddr_h_d   = ({ph_q, 1'b0} < div_q);
            ddr_l_d   = ({ph_q, 1'b1} < div_q);
            clk_en_d  = (ph_q == '0);
            running_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_STOP;
            ph_q       <= '0;
            div_q      <= DW'(DIV_100);
            spd_q      <= SPD_100;
            chg_q      <= 1'b0;
            ddr_h_q    <= 1'b0;
            ddr_l_q    <= 1'b0;
            clk_en_q   <= 1'b0;
            running_q  <= 1'b0;
            speed_q    <= SPD_100;
            mode_chg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            div_q      <= div_d;
            spd_q      <= spd_d;
            chg_q      <= chg_d;
            ddr_h_q    <= ddr_h_d;
            ddr_l_q    <= ddr_l_d;
            clk_en_q   <= clk_en_d;
            running_q  <= running_d;
            speed_q    <= speed_d;
            mode_chg_q <= mode_chg_d;
        end
    end

    assign ddr_h    = ddr_h_q;
    assign ddr_l    = ddr_l_q;
    assign clk_en   = clk_en_q;
    assign running  = running_q;
    assign speed    = speed_q;
    assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_eth_tx_clkgen.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_clkgen
//
// Directed bench for eth_tx_clkgen at default divisors (1 / 5 / 50).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. they show what the DUT registered on that edge.
// Observed vector layout: {ddr_h, ddr_l, clk_en, running, speed[1:0], mode_chg}
// -----------------------------------------------------------------------------
module tb_eth_tx_clkgen;

    logic       clk;
    logic       reset;
    logic       run_en;
    logic       eth_mode;
    logic       ena_10;
    logic       ddr_h;
    logic       ddr_l;
    logic       clk_en;
    logic       running;
    logic [1:0] speed;
    logic       mode_chg;

    logic [6:0] obs;
    logic [6:0] exp_v;

    int n_vec = 0;
    int n_err = 0;

    assign obs = {ddr_h, ddr_l, clk_en, running, speed, mode_chg};

    eth_tx_clkgen #(
        .DIV_1000(1),
        .DIV_100 (5),
        .DIV_10  (50),
        .CNT_W   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run_en  (run_en),
        .eth_mode(eth_mode),
        .ena_10  (ena_10),
        .ddr_h   (ddr_h),
        .ddr_l   (ddr_l),
        .clk_en  (clk_en),
        .running (running),
        .speed   (speed),
        .mode_chg(mode_chg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected output vector while running at phase k of a div-cycle period.
    function automatic logic [6:0] run_vec(input int div, input logic [1:0] spd,
                                           input logic mc, input int k);
        logic h, l, ce;
        h  = ((2 * k) < div);
        l  = ((2 * k + 1) < div);
        ce = (k == 0);
        return {h, l, ce, 1'b1, spd, mc && (k == 0)};
    endfunction

    function automatic logic [6:0] idle_vec(input logic [1:0] spd);
        return {4'b0000, spd, 1'b0};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; run_en = 1'b1; eth_mode = 1'b1; ena_10 = 1'b0;
        repeat (3) tick();
        exp_v = idle_vec(2'b00);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_reset held: got %b want %b", obs, exp_v);
        end
        reset = 1'b0; run_en = 1'b0; eth_mode = 1'b0;
        tick();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_reset released: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_100();
        run_en = 1'b1; eth_mode = 1'b0; ena_10 = 1'b0;
        tick();  // run_en sampled: outputs still idle
        exp_v = idle_vec(2'b00);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_100 startup: got %b want %b", obs, exp_v);
        end
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                exp_v = run_vec(5, 2'b00, 1'b0, k);
                n_vec++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL test_100 period %0d ph %0d: got %b want %b", p, k, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_stop();
        // Output ph0 now; internal phase is 1 when run_en drops.
        tick();
        exp_v = run_vec(5, 2'b00, 1'b0, 0);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_stop ph 0: got %b want %b", obs, exp_v);
        end
        run_en = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            exp_v = run_vec(5, 2'b00, 1'b0, k);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_stop finishing ph %0d: got %b want %b", k, obs, exp_v);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = idle_vec(2'b00);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_stop idle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        // Restart: idle for one more cycle, then ph0.
        run_en = 1'b1;
        tick();
        exp_v = idle_vec(2'b00);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_stop restart latency: got %b want %b", obs, exp_v);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_v = run_vec(5, 2'b00, 1'b0, k);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_stop restart ph %0d: got %b want %b", k, obs, exp_v);
            end
        end
        // Stop cleanly at the next boundary.
        run_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_v = run_vec(5, 2'b00, 1'b0, k);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_stop drain ph %0d: got %b want %b", k, obs, exp_v);
            end
        end
        tick();
        exp_v = idle_vec(2'b00);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_stop drained: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_gigabit();
        run_en = 1'b1; eth_mode = 1'b1; ena_10 = 1'b0;
        tick();
        exp_v = idle_vec(2'b00);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_gigabit startup: got %b want %b", obs, exp_v);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_v = run_vec(1, 2'b10, (i == 0), 0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_gigabit cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        // div=1: every cycle is a boundary, so the stop is immediate.
        run_en = 1'b0;
        tick();
        exp_v = run_vec(1, 2'b10, 1'b0, 0);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_gigabit last: got %b want %b", obs, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = idle_vec(2'b10);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_gigabit idle %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_10_and_speed_change();
        int n_ce;
        run_en = 1'b1; eth_mode = 1'b0; ena_10 = 1'b1;
        tick();
        exp_v = idle_vec(2'b10);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_10 startup: got %b want %b", obs, exp_v);
        end
        // First period (mode_chg pulses) and a full second period.
        n_ce = 0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 50; k++) begin
                tick();
                if (clk_en) n_ce++;
                exp_v = run_vec(50, 2'b01, (p == 0), k);
                n_vec++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL test_10 period %0d ph %0d: got %b want %b", p, k, obs, exp_v);
                end
            end
        end
        n_vec++;
        if (n_ce !== 2) begin
            n_err++;
            $display("FAIL test_10 clk_en count: got %0d want 2", n_ce);
        end
        // Third period: request gigabit while the internal phase is 10.
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_v = run_vec(50, 2'b01, 1'b0, k);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_change pre ph %0d: got %b want %b", k, obs, exp_v);
            end
        end
        eth_mode = 1'b1;
        for (int k = 10; k < 50; k++) begin
            tick();
            exp_v = run_vec(50, 2'b01, 1'b0, k);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_change hold ph %0d: got %b want %b", k, obs, exp_v);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = run_vec(1, 2'b10, (i == 0), 0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_change gig cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_period();
        // Back to 10 Mb: loaded at the next gigabit boundary.
        eth_mode = 1'b0; ena_10 = 1'b1;
        tick();
        exp_v = run_vec(1, 2'b10, 1'b0, 0);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_reset_mid last gig: got %b want %b", obs, exp_v);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_v = run_vec(50, 2'b01, 1'b1, k);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_reset_mid ph %0d: got %b want %b", k, obs, exp_v);
            end
        end
        // Internal phase is 20 here.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = idle_vec(2'b00);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL test_reset_mid in reset %0d: got %b want %b", i, obs, exp_v);
            end
        end
        reset = 1'b0; run_en = 1'b0;
        tick();
        exp_v = idle_vec(2'b00);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL test_reset_mid after: got %b want %b", obs, exp_v);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; run_en = 1'b0; eth_mode = 1'b0; ena_10 = 1'b0;
        test_reset();
        test_100();
        test_stop();
        test_gigabit();
        test_10_and_speed_change();
        test_reset_mid_period();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
